// File: rtl/spi_loader.sv
// spi_loader: SPI slave front end for the program/data memory loader.
// Receives 10-bit frames (2-bit op, 8-bit data) while ssel is low and
// decodes them into write strobes with an auto-incrementing address.
// Optional feature macro: SPI_READBACK_EN enables MISO readback of the
// data memory word at wr_addr. Without it, ssp1_miso is tied low.
module spi_loader (
  input  logic       clk,
  input  logic       reset,
  input  logic       ssp1_sck,
  input  logic       ssp1_ssel,
  input  logic       ssp1_mosi,
  output logic       ssp1_miso,
  output logic       wr_prog,
  output logic       wr_mem,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] rd_data,
  output logic       frame_err,
  output logic       sck_sync,
  output logic       ssel_sync,
  output logic       mosi_sync
);

  // Per pin: [0] IOB stage, [1] synchronised value, [2] delayed copy for edges.
  logic [2:0] sck_q, ssel_q, mosi_q;

  logic [3:0] bit_ctr_q, bit_ctr_d;
  logic [9:0] shift_q, shift_d;

  logic [7:0] wr_addr_q, wr_data_q;
  logic       wr_prog_q, wr_mem_q, frame_err_q;
  // Address increment deferred one clk so the strobe shows the old address.
  logic       inc_q;

  logic sck_rise, sck_fall, ssel_fall, ssel_rise, ssel_low, mosi_s;

  assign sck_rise  = sck_q[1] & ~sck_q[2];
  assign sck_fall  = ~sck_q[1] & sck_q[2];
  assign ssel_fall = ~ssel_q[1] & ssel_q[2];
  assign ssel_rise = ssel_q[1] & ~ssel_q[2];
  assign ssel_low  = ~ssel_q[1];
  assign mosi_s    = mosi_q[1];

  assign sck_sync  = sck_q[1];
  assign ssel_sync = ssel_q[1];
  assign mosi_sync = mosi_q[1];

  // Two-flop synchronisers plus a delayed copy for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_q  <= 3'b000;
      ssel_q <= 3'b111;
      mosi_q <= 3'b000;
    end else begin
      sck_q  <= {sck_q[1:0], ssp1_sck};
      ssel_q <= {ssel_q[1:0], ssp1_ssel};
      mosi_q <= {mosi_q[1:0], ssp1_mosi};
    end
  end

  // Frame capture: a ssel fall restarts the frame and wins over a
  // coincident sck rise; the bit counter saturates at 11.
  always_comb begin
    bit_ctr_d = bit_ctr_q;
    shift_d   = shift_q;
    if (ssel_fall) begin
      bit_ctr_d = 4'd0;
      shift_d   = 10'd0;
    end else if (sck_rise && ssel_low) begin
      shift_d = {shift_q[8:0], mosi_s};
      if (bit_ctr_q != 4'd11) bit_ctr_d = bit_ctr_q + 4'd1;
    end
  end

  // Frame capture registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_ctr_q <= 4'd0;
      shift_q   <= 10'd0;
    end else begin
      bit_ctr_q <= bit_ctr_d;
      shift_q   <= shift_d;
    end
  end

  // Frame execution on the synchronised ssel rise: one-clk strobes, then
  // the address increment on the following edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr_q   <= 8'd0;
      wr_data_q   <= 8'd0;
      wr_prog_q   <= 1'b0;
      wr_mem_q    <= 1'b0;
      frame_err_q <= 1'b0;
      inc_q       <= 1'b0;
    end else begin
      wr_prog_q   <= 1'b0;
      wr_mem_q    <= 1'b0;
      frame_err_q <= 1'b0;
      inc_q       <= 1'b0;
      if (inc_q) wr_addr_q <= wr_addr_q + 8'd1;
      if (ssel_rise) begin
        if (bit_ctr_q == 4'd10) begin
          case (shift_q[9:8])
            2'b00: wr_addr_q <= shift_q[7:0];
            2'b01: begin
              wr_prog_q <= 1'b1;
              wr_data_q <= shift_q[7:0];
              inc_q     <= 1'b1;
            end
            2'b10: inc_q <= 1'b1;
            default: begin
              wr_mem_q  <= 1'b1;
              wr_data_q <= shift_q[7:0];
              inc_q     <= 1'b1;
            end
          endcase
        end else begin
          frame_err_q <= 1'b1;
        end
      end
    end
  end

  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_prog   = wr_prog_q;
  assign wr_mem    = wr_mem_q;
  assign frame_err = frame_err_q;

`ifdef SPI_READBACK_EN
  logic [7:0] out_sr_q;
  logic       miso_q;

  // Readback: load the memory word on the second sck rise, shift it out
  // MSB first on the falls that follow rises 2..9; low otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_sr_q <= 8'd0;
      miso_q   <= 1'b0;
    end else if (!ssel_low) begin
      miso_q <= 1'b0;
    end else begin
      if (sck_rise && !ssel_fall && bit_ctr_q == 4'd1) out_sr_q <= rd_data;
      if (sck_fall) begin
        if (bit_ctr_q >= 4'd2 && bit_ctr_q <= 4'd9) begin
          miso_q   <= out_sr_q[7];
          out_sr_q <= {out_sr_q[6:0], 1'b0};
        end else begin
          miso_q <= 1'b0;
        end
      end
    end
  end

  assign ssp1_miso = miso_q;
`else
  logic unused_rd_data;
  assign unused_rd_data = ^rd_data;
  assign ssp1_miso      = 1'b0;
`endif

endmodule
